// File: rtl/sisc_fetch_unit.sv
// SISC instruction-fetch stage: program counter, branch-target math, and an
// instruction register filled over a req/ack memory handshake with timeout.
module sisc_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ir_load,
  input  logic              pc_write,
  input  logic              pc_sel,
  input  logic              br_sel,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       ir,
  output logic [3:0]        opcode,
  output logic [3:0]        mm,
  output logic [3:0]        rd_f,
  output logic [3:0]        rs_f,
  output logic [3:0]        rt_f,
  output logic [15:0]       imm,
  output logic [ADDR_W-1:0] pc_out,
  output logic              ir_valid,
  output logic              fetch_busy,
  output logic              halted,
  output logic              fetch_err
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  pc, pc_upd, pc_inc, imm_a;
  logic               start, done_ack, done_to, pc_we, timeout_hit;

  assign opcode = ir[31:28];
  assign mm     = ir[27:24];
  assign rd_f   = ir[23:20];
  assign rs_f   = ir[19:16];
  assign rt_f   = ir[15:12];
  assign imm    = ir[15:0];
  assign pc_out = pc;

  assign imm_a       = ADDR_W'(imm);
  assign pc_inc      = pc + ADDR_W'(1);
  assign pc_upd      = pc_sel ? (br_sel ? imm_a : pc_inc + imm_a) : pc_inc;
  assign pc_we       = pc_write && (state == S_IDLE);
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d  = state;
    start    = 1'b0;
    done_ack = 1'b0;
    done_to  = 1'b0;
    case (state)
      S_IDLE: if (ir_load && !halted) begin
        state_d = S_WAIT;
        start   = 1'b1;
      end
      S_WAIT: if (imem_ack) begin
        state_d  = S_IDLE;
        done_ack = 1'b1;
      end else if (timeout_hit) begin
        state_d = S_IDLE;
        done_to = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      imem_addr  <= RESET_PC;
      ir         <= '0;
      ir_valid   <= 1'b0;
      imem_req   <= 1'b0;
      fetch_busy <= 1'b0;
      halted     <= 1'b0;
      fetch_err  <= 1'b0;
      cnt        <= '0;
    end else begin
      if (pc_we) pc <= pc_upd;
      // The fetch address must not move under an outstanding request.
      if (state == S_WAIT && pc_write) fetch_err <= 1'b1;
      if (start) begin
        imem_req   <= 1'b1;
        fetch_busy <= 1'b1;
        imem_addr  <= pc;
        ir_valid   <= 1'b0;
        cnt        <= '0;
      end else if (state == S_IDLE) begin
        imem_addr <= pc_we ? pc_upd : pc;
      end
      if (done_ack) begin
        ir         <= imem_rdata;
        ir_valid   <= 1'b1;
        imem_req   <= 1'b0;
        fetch_busy <= 1'b0;
        halted     <= (imem_rdata[31:28] == 4'hF);
      end else if (done_to) begin
        ir         <= '0;
        ir_valid   <= 1'b1;
        imem_req   <= 1'b0;
        fetch_busy <= 1'b0;
        halted     <= 1'b0;
        fetch_err  <= 1'b1;
      end else if (state == S_WAIT) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_sisc_fetch_unit.sv
// Bench for sisc_fetch_unit: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level reference model.
module tb_sisc_fetch_unit;
  localparam int TO = 15;

  logic        clk = 1'b0, rst = 1'b1;
  logic        ir_load = 0, pc_write = 0, pc_sel = 0, br_sel = 0, imem_ack = 0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req, ir_valid, fetch_busy, halted, fetch_err;
  logic [15:0] imem_addr, pc_out, imm;
  logic [31:0] ir;
  logic [3:0]  opcode, mm, rd_f, rs_f, rt_f;

  int n_chk = 0, n_fail = 0;

  // reference model state
  logic [15:0] m_pc, m_addr;
  logic [31:0] m_ir;
  logic        m_valid, m_busy, m_halt, m_err;
  int          m_age;

  sisc_fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ir_load(ir_load), .pc_write(pc_write),
    .pc_sel(pc_sel), .br_sel(br_sel), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir(ir), .opcode(opcode), .mm(mm), .rd_f(rd_f), .rs_f(rs_f),
    .rt_f(rt_f), .imm(imm), .pc_out(pc_out), .ir_valid(ir_valid),
    .fetch_busy(fetch_busy), .halted(halted), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0; m_addr = 16'h0; m_ir = '0;
    m_valid = 0; m_busy = 0; m_halt = 0; m_err = 0; m_age = 0;
  endtask

  // One clock edge of the fetch stage, expressed as transaction rules.
  task automatic model_edge(input logic ld, pw, ps, bs, ack, input logic [31:0] rd);
    logic [15:0] tgt, npc;
    if (m_busy) begin
      if (pw) m_err = 1;
      if (ack) begin
        m_ir = rd; m_valid = 1; m_busy = 0; m_halt = (rd[31:28] == 4'hF);
      end else begin
        m_age++;
        if (m_age == TO) begin
          m_ir = '0; m_valid = 1; m_busy = 0; m_halt = 0; m_err = 1;
        end
      end
    end else begin
      tgt = ps ? (bs ? m_ir[15:0] : m_pc + 16'd1 + m_ir[15:0]) : m_pc + 16'd1;
      npc = pw ? tgt : m_pc;
      if (ld && !m_halt) begin
        m_busy = 1; m_age = 0; m_valid = 0; m_addr = m_pc;
      end else begin
        m_addr = npc;
      end
      m_pc = npc;
    end
  endtask

  task automatic check_all();
    chk("pc", pc_out, m_pc);
    chk("addr", imem_addr, m_addr);
    chk("ir", ir, m_ir);
    chk("ir_valid", ir_valid, m_valid);
    chk("imem_req", imem_req, m_busy);
    chk("fetch_busy", fetch_busy, m_busy);
    chk("halted", halted, m_halt);
    chk("fetch_err", fetch_err, m_err);
    chk("opcode", opcode, m_ir[31:28]);
    chk("rt_f", rt_f, m_ir[15:12]);
    chk("imm", imm, m_ir[15:0]);
  endtask

  task automatic step(input logic ld, pw, ps, bs, ack, input logic [31:0] rd);
    ir_load = ld; pc_write = pw; pc_sel = ps; br_sel = bs; imem_ack = ack; imem_rdata = rd;
    @(posedge clk);
    model_edge(ld, pw, ps, bs, ack, rd);
    #1 check_all();
  endtask

  // Asserted between edges so the asynchronous path is what gets observed.
  task automatic do_reset();
    ir_load = 0; pc_write = 0; pc_sel = 0; br_sel = 0; imem_ack = 0;
    rst = 1;
    #2;
    model_reset();
    check_all();
    @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic fetch(input logic [31:0] w);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, w);
  endtask

  initial begin
    logic [15:0] a0, p0;
    int nreq, pct;
    @(posedge clk); #1;
    do_reset();

    // basic fetch, ack in first request cycle
    step(1, 0, 0, 0, 0, 0);
    chk("req_addr", imem_addr, 16'h0);
    step(0, 0, 0, 0, 1, 32'h1123_0000);
    chk("t1_valid", ir_valid, 1);
    chk("t1_opcode", opcode, 4'h1);
    chk("t1_mm", mm, 4'h1);
    chk("t1_rd", rd_f, 4'h2);
    chk("t1_rs", rs_f, 4'h3);
    chk("t1_pc", pc_out, 16'h0);

    // branch target arithmetic
    fetch(32'h0000_0010); step(0, 1, 1, 1, 0, 0);
    chk("pc_abs10", pc_out, 16'h0010);
    fetch(32'h0000_FFFE); step(0, 1, 1, 0, 0, 0);
    chk("pc_rel", pc_out, 16'h000F);
    fetch(32'h0000_0040); step(0, 1, 1, 1, 0, 0);
    chk("pc_abs40", pc_out, 16'h0040);
    fetch(32'h0000_FFFF); step(0, 1, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("pc_wrap", pc_out, 16'h0000);
    // load and pc_write on the same edge: fetch uses the old PC
    step(1, 1, 0, 0, 0, 0);
    chk("ld_pw_addr", imem_addr, 16'h0000);
    chk("ld_pw_pc", pc_out, 16'h0001);
    step(0, 0, 0, 0, 1, 32'h0000_0003);

    // ack delayed 5 cycles, ir_load mid-WAIT ignored
    step(1, 0, 0, 0, 0, 0);
    a0 = imem_addr; nreq = int'(imem_req);
    for (int i = 0; i < 4; i++) begin
      step(i == 1, 0, 0, 0, 0, 0);
      nreq += int'(imem_req);
      chk("addr_stable", imem_addr, a0);
    end
    step(0, 0, 0, 0, 1, 32'h2000_1234);
    chk("req_cycles", nreq, 5);
    chk("req_drop", imem_req, 0);

    // timeout, then ack on the timeout edge
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < TO - 1; i++) step(0, 0, 0, 0, 0, 0);
    chk("to_still_busy", fetch_busy, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("to_ir", ir, 32'h0);
    chk("to_valid", ir_valid, 1);
    chk("to_err", fetch_err, 1);
    do_reset();
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < TO - 1; i++) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h2345_6789);
    chk("late_ack_ir", ir, 32'h2345_6789);
    chk("late_ack_err", fetch_err, 0);

    // pc_write while waiting
    step(1, 0, 0, 0, 0, 0);
    p0 = pc_out;
    step(0, 1, 0, 0, 0, 0);
    chk("wait_pw_pc", pc_out, p0);
    chk("wait_pw_err", fetch_err, 1);
    step(0, 0, 0, 0, 1, 32'h3000_0000);
    chk("wait_pw_done", ir_valid, 1);
    do_reset();

    // halt, then async reset mid-WAIT
    fetch(32'hF000_0000);
    chk("halt", halted, 1);
    step(1, 0, 0, 0, 0, 0);
    chk("halt_noreq", imem_req, 0);
    do_reset();
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("pre_rst_req", imem_req, 1);
    do_reset();
    step(0, 0, 0, 0, 1, 32'h1234_5678);
    chk("post_rst_ir", ir, 32'h0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) do_reset();
      case ((c / 500) % 3)
        0: pct = 40;
        1: pct = 10;
        default: pct = 0;
      endcase
      step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 10,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 99) < pct, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
